// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg
// This package holds the shared constants and types for the stack machine
// controller:
//   - opcode values for the IR field inst[7:5]
//   - 4-bit FSM state encodings
//   - ALUControl codes and ALUSrcA codes
//   - ctrl_t, the packed bundle of every control output
// Build option: the STKCTRL_PERF_EN macro is consumed by stack_controller,
// not by this package.
package stack_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_CONST = 2'b01;
  localparam logic [1:0] SRCA_AOUT  = 2'b10;

  // Encodings 14 and 15 are unused. They must fall back to IF.
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_POP     = 4'd2,
    S_POP_LDA = 4'd3,
    S_LDB     = 4'd4,
    S_LDA     = 4'd5,
    S_EX      = 4'd6,
    S_WB      = 4'd7,
    S_MEMRD   = 4'd8,
    S_PUSHWB  = 4'd9,
    S_MEMWR   = 4'd10,
    S_JMP     = 4'd11,
    S_TOS     = 4'd12,
    S_JZ      = 4'd13
  } state_t;

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       tos;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       stack_src;
    logic       ld_a;
    logic       ld_b;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       pc_src;
    logic [1:0] alu_control;
  } ctrl_t;

  // The last state of every instruction. Each of these returns to IF.
  function automatic logic is_terminal(state_t s);
    return (s == S_WB) || (s == S_PUSHWB) || (s == S_MEMWR) ||
           (s == S_JMP) || (s == S_JZ);
  endfunction

endpackage

// File: rtl/stack_controller_if.sv
// stack_controller_if
// This interface carries the bus between the controller and the stack
// machine datapath.
// Signals:
//   - OPC: the opcode from the IR, driven by the datapath
//   - all control strobes and selects, driven by the controller
// Modports:
//   - master: the controller
//   - slave: the datapath
interface stack_controller_if;
  logic [2:0] OPC;
  logic       push;
  logic       pop;
  logic       tos;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic       StackSrc;
  logic       ldA;
  logic       ldB;
  logic [1:0] ALUSrcA;
  logic       ALUSrcB;
  logic       PCSrc;
  logic [1:0] ALUControl;

  modport master (
    input  OPC,
    output push, pop, tos, PCWrite, PCWriteCond, IorD, MemWrite, MemRead,
           IRWrite, StackSrc, ldA, ldB, ALUSrcA, ALUSrcB, PCSrc, ALUControl
  );

  modport slave (
    output OPC,
    input  push, pop, tos, PCWrite, PCWriteCond, IorD, MemWrite, MemRead,
           IRWrite, StackSrc, ldA, ldB, ALUSrcA, ALUSrcB, PCSrc, ALUControl
  );
endinterface

// File: rtl/stack_ctrl_decode.sv
// stack_ctrl_decode
// This is the combinational Moore output map of the stack controller.
// Ports:
//   - state: the current FSM state
//   - opc:   the opcode, used only to choose the ALU function in EX
//   - ctrl:  the full control bundle
// Any state that does not appear in the case statement drives all outputs to 0.
module stack_ctrl_decode
  import stack_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] opc,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = 1'b1;
      end
      S_POP:     ctrl.pop = 1'b1;
      S_POP_LDA: begin
        ctrl.pop  = 1'b1;
        ctrl.ld_a = 1'b1;
      end
      S_LDB:     ctrl.ld_b = 1'b1;
      S_LDA:     ctrl.ld_a = 1'b1;
      S_EX: begin
        ctrl.alu_src_a = SRCA_AOUT;
        ctrl.alu_src_b = 1'b0;
        case (opc)
          OP_SUB:  ctrl.alu_control = ALU_SUB;
          OP_AND:  ctrl.alu_control = ALU_AND;
          OP_NOT:  ctrl.alu_control = ALU_NOT;
          default: ctrl.alu_control = ALU_ADD;
        endcase
      end
      S_WB:      ctrl.push = 1'b1;
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_PUSHWB: begin
        ctrl.push      = 1'b1;
        ctrl.stack_src = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_src   = 1'b1;
        ctrl.pc_write = 1'b1;
      end
      S_TOS:     ctrl.tos = 1'b1;
      S_JZ: begin
        ctrl.pc_src        = 1'b1;
        ctrl.pc_write_cond = 1'b1;
      end
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/stack_controller.sv
// stack_controller
// This is the multicycle Moore control unit for an 8-bit stack machine.
// Ports:
//   - clk, rst: the clock and an asynchronous active-high reset
//   - bus:      the stack_controller_if master modport (OPC in, controls out)
//   - retired:  a 16-bit saturating count of retired instructions
//               (present only when STKCTRL_PERF_EN is defined)
// Build option: STKCTRL_PERF_EN adds the retired-instruction counter.
// The FSM is the same with or without it.
module stack_controller
  import stack_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  stack_controller_if.master  bus
`ifdef STKCTRL_PERF_EN
  ,
  output logic [15:0]         retired
`endif
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // OPC is read in every state after ID. The IR only loads in IF, so OPC
  // stays stable for the whole instruction.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (bus.OPC)
          OP_PUSH: state_d = S_MEMRD;
          OP_JMP:  state_d = S_JMP;
          OP_JZ:   state_d = S_TOS;
          default: state_d = S_POP;
        endcase
      end
      S_POP: begin
        if (bus.OPC == OP_ADD || bus.OPC == OP_SUB || bus.OPC == OP_AND)
          state_d = S_POP_LDA;
        else
          state_d = S_LDA;
      end
      S_POP_LDA: state_d = S_LDB;
      S_LDB:     state_d = S_EX;
      S_LDA: begin
        case (bus.OPC)
          OP_NOT:  state_d = S_EX;
          OP_POP:  state_d = S_MEMWR;
          OP_JZ:   state_d = S_JZ;
          default: state_d = S_IF;
        endcase
      end
      S_EX:      state_d = S_WB;
      S_MEMRD:   state_d = S_PUSHWB;
      S_TOS:     state_d = S_LDA;
      default:   state_d = S_IF;
    endcase
  end

  stack_ctrl_decode u_decode (
    .state (state_q),
    .opc   (bus.OPC),
    .ctrl  (ctrl_raw)
  );

  // While rst is held, the state register already reads IF. The IF strobes
  // must stay quiet anyway, so the outputs are gated by rst directly.
  assign ctrl_out = rst ? '0 : ctrl_raw;

  assign bus.push        = ctrl_out.push;
  assign bus.pop         = ctrl_out.pop;
  assign bus.tos         = ctrl_out.tos;
  assign bus.PCWrite     = ctrl_out.pc_write;
  assign bus.PCWriteCond = ctrl_out.pc_write_cond;
  assign bus.IorD        = ctrl_out.iord;
  assign bus.MemWrite    = ctrl_out.mem_write;
  assign bus.MemRead     = ctrl_out.mem_read;
  assign bus.IRWrite     = ctrl_out.ir_write;
  assign bus.StackSrc    = ctrl_out.stack_src;
  assign bus.ldA         = ctrl_out.ld_a;
  assign bus.ldB         = ctrl_out.ld_b;
  assign bus.ALUSrcA     = ctrl_out.alu_src_a;
  assign bus.ALUSrcB     = ctrl_out.alu_src_b;
  assign bus.PCSrc       = ctrl_out.pc_src;
  assign bus.ALUControl  = ctrl_out.alu_control;

`ifdef STKCTRL_PERF_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retired_q <= 16'd0;
    else if (is_terminal(state_q) && (state_d == S_IF) && (retired_q != 16'hFFFF))
      retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`endif

endmodule
